reg_pipe_vr: RTL and testbench

Parametrised, elastic multi-stage pipeline register with valid/ready handshaking, per-stage bubble collapsing, synchronous flush, and an occupancy count. It generalises the plain enabled register: width and depth are parameters, and a downstream stall back-pressures the chain instead of relying on a global enable. It sits between latency-tolerant producer/consumer blocks that need a fixed minimum delay plus elastic buffering.

---
 rtl/reg_pipe_vr.sv | 56 +++++
 tb/tb_reg_pipe_vr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe_vr.sv
// reg_pipe_vr: elastic valid/ready pipeline register with bubble collapsing, flush and occupancy count
module reg_pipe_vr #(
  parameter int p_nbits   = 4,
  parameter int p_nstages = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_val,
  output logic                               in_rdy,
  input  logic [p_nbits-1:0]                 in_msg,
  output logic                               out_val,
  input  logic                               out_rdy,
  output logic [p_nbits-1:0]                 out_msg,
  output logic [$clog2(p_nstages+1)-1:0]     count
);
  localparam int L  = p_nstages - 1;
  localparam int CW = $clog2(p_nstages + 1);
  logic [p_nstages-1:0] v;
  logic [p_nstages-1:0] go;
  logic [p_nbits-1:0]   d [p_nstages];
  logic                 in_xfer;
  // A stage advances unless every stage ahead of it is occupied and the output stalls.
  always_comb begin
    logic all_v;
    all_v = 1'b1;
    go = '0;
    for (int i = L; i >= 0; i--) begin
      go[i] = v[i] & (~all_v | out_rdy);
      all_v = all_v & v[i];
    end
  end
  always_comb begin
    count = '0;
    for (int i = 0; i < p_nstages; i++) count = count + CW'(v[i]);
  end
  assign in_rdy  = (~v[0] | go[0]) & ~flush;
  assign in_xfer = in_val & in_rdy;
  assign out_val = v[L] & ~flush;
  assign out_msg = d[L];
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < p_nstages; i++) d[i] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      v[0] <= in_xfer | (v[0] & ~go[0]);
      if (in_xfer) d[0] <= in_msg;
      for (int i = 1; i < p_nstages; i++) begin
        v[i] <= go[i-1] | (v[i] & ~go[i]);
        if (go[i-1]) d[i] <= d[i-1];
      end
    end
  end
endmodule

// File: tb/tb_reg_pipe_vr.sv
// tb_reg_pipe_vr: directed checks on 2- and 3-stage pipes, randomized traffic on a 4-stage pipe vs a position model
module tb_reg_pipe_vr;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_flush = 0, a_in_val = 0, a_in_rdy, a_out_val, a_out_rdy = 0;
  logic [3:0] a_in_msg = 0, a_out_msg;
  logic [1:0] a_count;
  logic       b_flush = 0, b_in_val = 0, b_in_rdy, b_out_val, b_out_rdy = 0;
  logic [3:0] b_in_msg = 0, b_out_msg;
  logic [1:0] b_count;
  logic       c_flush = 0, c_in_val = 0, c_in_rdy, c_out_val, c_out_rdy = 0;
  logic [7:0] c_in_msg = 0, c_out_msg;
  logic [2:0] c_count;

  reg_pipe_vr #(.p_nbits(4), .p_nstages(2)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_val(a_in_val), .in_rdy(a_in_rdy),
    .in_msg(a_in_msg), .out_val(a_out_val), .out_rdy(a_out_rdy), .out_msg(a_out_msg), .count(a_count));
  reg_pipe_vr #(.p_nbits(4), .p_nstages(3)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_val(b_in_val), .in_rdy(b_in_rdy),
    .in_msg(b_in_msg), .out_val(b_out_val), .out_rdy(b_out_rdy), .out_msg(b_out_msg), .count(b_count));
  reg_pipe_vr #(.p_nbits(8), .p_nstages(4)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_val(c_in_val), .in_rdy(c_in_rdy),
    .in_msg(c_in_msg), .out_val(c_out_val), .out_rdy(c_out_rdy), .out_msg(c_out_msg), .count(c_count));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-traffic model: each in-flight message is a (position, payload, accept cycle);
  // a message moves up one slot per cycle unless the slot just below its predecessor's new place caps it.
  int         pq[$];
  logic [7:0] mq[$];
  int         aq[$];

  initial begin
    int exp_cnt [7] = '{0, 1, 2, 2, 2, 1, 0};
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_out_val", 32'(a_out_val), 0);
    chk("rst_out_msg", 32'(a_out_msg), 0);
    chk("rst_in_rdy", 32'(a_in_rdy), 1);

    // streaming 1,2,3,4 with out_rdy held high
    a_out_rdy = 1;
    for (int j = 0; j < 7; j++) begin
      a_in_val = (j < 4);
      a_in_msg = 4'(j + 1);
      #1;
      chk("stream_count", 32'(a_count), 32'(exp_cnt[j]));
      chk("stream_out_val", 32'(a_out_val), 32'(j >= 2 && j <= 5));
      if (j >= 2 && j <= 5) chk("stream_out_msg", 32'(a_out_msg), 32'(j - 1));
      if (j < 4) chk("stream_in_rdy", 32'(a_in_rdy), 1);
      tick();
    end

    // backpressure fill with A,B then C blocked
    a_out_rdy = 0;
    a_in_val = 1;
    a_in_msg = 4'hA;
    #1 chk("bp_rdy_a", 32'(a_in_rdy), 1);
    tick();
    a_in_msg = 4'hB;
    #1 chk("bp_rdy_b", 32'(a_in_rdy), 1);
    tick();
    a_in_msg = 4'hC;
    #1;
    chk("bp_full_count", 32'(a_count), 2);
    chk("bp_full_rdy", 32'(a_in_rdy), 0);
    chk("bp_full_out_val", 32'(a_out_val), 1);
    chk("bp_full_out_msg", 32'(a_out_msg), 32'hA);
    tick();
    chk("bp_hold_count", 32'(a_count), 2);
    chk("bp_hold_rdy", 32'(a_in_rdy), 0);
    a_out_rdy = 1;
    #1;
    chk("bp_release_rdy", 32'(a_in_rdy), 1);
    chk("bp_out_a", 32'(a_out_msg), 32'hA);
    tick();
    a_in_val = 0;
    #1;
    chk("bp_out_b_val", 32'(a_out_val), 1);
    chk("bp_out_b", 32'(a_out_msg), 32'hB);
    tick();
    chk("bp_out_c", 32'(a_out_msg), 32'hC);
    tick();
    chk("bp_empty_val", 32'(a_out_val), 0);
    chk("bp_empty_count", 32'(a_count), 0);

    // full pipe with simultaneous push and pop for four cycles
    a_out_rdy = 0;
    a_in_val = 1;
    a_in_msg = 4'd1;
    tick();
    a_in_msg = 4'd2;
    tick();
    a_out_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      a_in_msg = 4'(k + 3);
      #1;
      chk("pp_in_rdy", 32'(a_in_rdy), 1);
      chk("pp_out_val", 32'(a_out_val), 1);
      chk("pp_out_msg", 32'(a_out_msg), 32'(k + 1));
      chk("pp_count", 32'(a_count), 2);
      tick();
    end
    a_in_val = 0;
    #1 chk("pp_drain5", 32'(a_out_msg), 5);
    tick();
    chk("pp_drain6", 32'(a_out_msg), 6);
    tick();
    chk("pp_drained", 32'(a_count), 0);

    // flush with both ports requesting a transfer
    a_out_rdy = 0;
    a_in_val = 1;
    a_in_msg = 4'h7;
    tick();
    a_in_msg = 4'h8;
    tick();
    a_flush = 1;
    a_out_rdy = 1;
    a_in_msg = 4'h9;
    #1;
    chk("fl_in_rdy", 32'(a_in_rdy), 0);
    chk("fl_out_val", 32'(a_out_val), 0);
    tick();
    a_flush = 0;
    a_in_val = 0;
    #1;
    chk("fl_count", 32'(a_count), 0);
    chk("fl_out_val_after", 32'(a_out_val), 0);
    chk("fl_data_kept", 32'(a_out_msg), 32'h7);
    a_in_val = 1;
    a_in_msg = 4'hD;
    #1 chk("fl_next_rdy", 32'(a_in_rdy), 1);
    tick();
    a_in_val = 0;
    #1 chk("fl_lat_early", 32'(a_out_val), 0);
    tick();
    chk("fl_lat_val", 32'(a_out_val), 1);
    chk("fl_lat_msg", 32'(a_out_msg), 32'hD);
    tick();

    // reset in the middle of traffic
    a_out_rdy = 0;
    a_in_val = 1;
    a_in_msg = 4'h3;
    tick();
    a_in_msg = 4'h4;
    tick();
    a_in_val = 0;
    chk("mr_count_before", 32'(a_count), 2);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("mr_count", 32'(a_count), 0);
    chk("mr_out_val", 32'(a_out_val), 0);
    chk("mr_out_msg", 32'(a_out_msg), 0);
    chk("mr_in_rdy", 32'(a_in_rdy), 1);

    // bubble collapse on the 3-stage pipe
    b_out_rdy = 0;
    b_in_val = 1;
    b_in_msg = 4'h5;
    tick();
    b_in_val = 0;
    tick();
    b_in_val = 1;
    b_in_msg = 4'h6;
    tick();
    b_in_val = 0;
    #1;
    chk("bub_count_mid", 32'(b_count), 2);
    chk("bub_out_val_mid", 32'(b_out_val), 1);
    tick();
    chk("bub_count", 32'(b_count), 2);
    chk("bub_out_val", 32'(b_out_val), 1);
    chk("bub_out_msg", 32'(b_out_msg), 32'h5);
    chk("bub_in_rdy", 32'(b_in_rdy), 1);

    // randomized traffic on the 4-stage pipe
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit ev;
      bit er;
      int lim;
      c_in_val = ($urandom_range(0, 3) != 0);
      c_out_rdy = ($urandom_range(0, 2) != 0);
      c_in_msg = 8'($urandom);
      #1;
      ev = (pq.size() > 0) && (pq[0] == 3);
      er = (pq.size() < 4) || c_out_rdy;
      chk("rnd_out_val", 32'(c_out_val), 32'(ev));
      if (ev) chk("rnd_out_msg", 32'(c_out_msg), 32'(mq[0]));
      chk("rnd_count", 32'(c_count), 32'(pq.size()));
      chk("rnd_in_rdy", 32'(c_in_rdy), 32'(er));
      chk("rnd_count_cap", 32'(c_count <= 3'd4), 1);
      if (ev && c_out_rdy) begin
        chk("rnd_latency", 32'(cyc - aq[0] >= 4), 1);
        void'(pq.pop_front());
        void'(mq.pop_front());
        void'(aq.pop_front());
      end
      lim = 3;
      for (int k = 0; k < pq.size(); k++) begin
        pq[k] = (pq[k] + 1 < lim) ? pq[k] + 1 : lim;
        lim = pq[k] - 1;
      end
      if (c_in_val && er) begin
        pq.push_back(0);
        mq.push_back(c_in_msg);
        aq.push_back(cyc);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
